// File: rtl/link_train.sv
// DisplayPort link-training sequencer: drives the PHY pattern select through
// clock recovery and channel equalisation while programming DPCD over AUX.
module link_train #(
  parameter int unsigned WAITCYC = 20000,
  parameter int unsigned MAXTRY  = 5
) (
  input  logic        dpclk,
  input  logic        reset,
  input  logic        start,
  input  logic        twolane,
  output logic [2:0]  phymode,
  output logic        auxreq,
  output logic        auxwr,
  output logic [19:0] auxaddr,
  output logic [7:0]  auxwdata,
  input  logic        auxack,
  input  logic [7:0]  auxrdata,
  input  logic        auxerr,
  output logic        busy,
  output logic        done,
  output logic        fail
);

  typedef enum logic [3:0] {
    IDLE, WRBW, WRLC, CRSET, CRWAIT, CRREAD,
    EQSET, EQWAIT, EQREAD, ALREAD, FINISH, FAIL
  } state_t;

  localparam logic [2:0]  PM_IDLE   = 3'd0;
  localparam logic [2:0]  PM_VIDEO  = 3'd1;
  localparam logic [2:0]  PM_TPS1   = 3'd2;
  localparam logic [2:0]  PM_TPS2   = 3'd3;
  localparam logic [15:0] WAIT_LAST = 16'(WAITCYC - 1);
  localparam logic [3:0]  TRY_LAST  = 4'(MAXTRY - 1);

  state_t      state;
  logic        lanes2;
  logic [3:0]  tries;
  logic [15:0] waitcnt;

  logic        ack;
  logic        launch;
  logic        req_wr;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        cr_pass;
  logic        eq_pass;
  logic        rdata_unused;

  // An acknowledge only counts against a request that is actually open.
  assign ack     = auxreq && auxack;
  assign cr_pass = auxrdata[0] && (!lanes2 || auxrdata[4]);
  assign eq_pass = (auxrdata[2:0] == 3'b111) && (!lanes2 || (auxrdata[6:4] == 3'b111));
  assign rdata_unused = auxrdata[7] ^ auxrdata[3];

  // Transaction each state launches, and when it launches it.
  // NOTE: every output gets a default first so this decode never infers a latch.
  always_comb begin
    launch    = 1'b0;
    req_wr    = 1'b1;
    req_addr  = 20'h00102;
    req_wdata = 8'h00;
    case (state)
      IDLE:   begin launch = start;   req_addr = 20'h00100; req_wdata = 8'h06; end
      WRLC:   begin launch = !auxreq; req_addr = 20'h00101;
                    req_wdata = {1'b1, 5'b0, lanes2 ? 2'd2 : 2'd1}; end
      CRSET:  begin launch = !auxreq; req_wdata = 8'h21; end
      EQSET:  begin launch = !auxreq; req_wdata = 8'h22; end
      CRWAIT, EQWAIT:
              begin launch = (waitcnt == WAIT_LAST); req_wr = 1'b0; req_addr = 20'h00202; end
      ALREAD: begin launch = !auxreq; req_wr = 1'b0; req_addr = 20'h00204; end
      FINISH, FAIL:
              launch = !auxreq;
      default: launch = 1'b0;
    endcase
  end

  // NOTE: all state updates are non-blocking so every branch sees pre-edge values.
  always_ff @(posedge dpclk) begin
    if (reset) begin
      state    <= IDLE;
      phymode  <= PM_IDLE;
      auxreq   <= 1'b0;
      auxwr    <= 1'b0;
      auxaddr  <= '0;
      auxwdata <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      lanes2   <= 1'b0;
      tries    <= '0;
      waitcnt  <= '0;
    end else begin
      if (launch) begin
        auxreq   <= 1'b1;
        auxwr    <= req_wr;
        auxaddr  <= req_addr;
        auxwdata <= req_wdata;
      end else if (ack) begin
        auxreq   <= 1'b0;
      end

      case (state)
        IDLE: if (start) begin
          busy   <= 1'b1;
          done   <= 1'b0;
          fail   <= 1'b0;
          lanes2 <= twolane;
          tries  <= '0;
          state  <= WRBW;
        end
        WRBW: if (ack) state <= WRLC;
        WRLC: if (ack) state <= CRSET;
        CRSET: begin
          if (launch) phymode <= PM_TPS1;
          if (ack) begin waitcnt <= '0; state <= CRWAIT; end
        end
        CRWAIT: begin
          waitcnt <= waitcnt + 16'd1;
          if (launch) state <= CRREAD;
        end
        CRREAD: if (ack) begin
          if (cr_pass) begin
            tries <= '0;
            state <= EQSET;
          end else if (tries == TRY_LAST) begin
            phymode <= PM_IDLE;
            state   <= FAIL;
          end else begin
            tries   <= tries + 4'd1;
            waitcnt <= '0;
            state   <= CRWAIT;
          end
        end
        EQSET: begin
          if (launch) phymode <= PM_TPS2;
          if (ack) begin waitcnt <= '0; state <= EQWAIT; end
        end
        EQWAIT: begin
          waitcnt <= waitcnt + 16'd1;
          if (launch) state <= EQREAD;
        end
        EQREAD: if (ack) begin
          if (eq_pass) begin
            state <= ALREAD;
          end else if (tries == TRY_LAST) begin
            phymode <= PM_IDLE;
            state   <= FAIL;
          end else begin
            tries   <= tries + 4'd1;
            waitcnt <= '0;
            state   <= EQWAIT;
          end
        end
        ALREAD: if (ack) begin
          if (auxrdata[0]) begin
            state <= FINISH;
          end else begin
            phymode <= PM_IDLE;
            state   <= FAIL;
          end
        end
        FINISH: if (ack && !auxerr) begin
          phymode <= PM_VIDEO;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        FAIL: if (ack) begin
          fail  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // The cleanup write is best effort; any other AUX error aborts training.
      if (ack && auxerr && (state != FAIL)) begin
        phymode <= PM_IDLE;
        state   <= FAIL;
      end
    end
  end

endmodule

// File: tb/tb_link_train.sv
// Self-checking bench for link_train: a reactive AUX responder plus a
// transaction-level model of the training sequence it should see.
module tb_link_train;

  localparam int WAITCYC = 12;
  localparam int MAXTRY  = 5;

  typedef struct packed {
    logic        wr;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [2:0]  mode;
    logic [15:0] gap;
  } txn_t;

  logic        dpclk = 1'b0;
  logic        reset, start, twolane, auxack, auxerr;
  logic [7:0]  auxrdata;
  logic [2:0]  phymode;
  logic        auxreq, auxwr, busy, done, fail;
  logic [19:0] auxaddr;
  logic [7:0]  auxwdata;

  link_train #(.WAITCYC(WAITCYC), .MAXTRY(MAXTRY)) dut (
    .dpclk(dpclk), .reset(reset), .start(start), .twolane(twolane),
    .phymode(phymode), .auxreq(auxreq), .auxwr(auxwr), .auxaddr(auxaddr),
    .auxwdata(auxwdata), .auxack(auxack), .auxrdata(auxrdata), .auxerr(auxerr),
    .busy(busy), .done(done), .fail(fail)
  );

  always #5 dpclk = ~dpclk;

  int cyc = 0;
  always @(posedge dpclk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_bad = 0;
  txn_t       exp_q[$];
  txn_t       got_q[$];
  logic [7:0] scen_rd[$];
  logic [7:0] mrd_q[$];
  logic [7:0] rsp_rd_q[$];
  int         err_at = -1;
  bit         rand_dly = 1'b0;
  int         last_ref = 0;
  int         proto_err = 0;
  logic [2:0] cur_mode = 3'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: expected AUX transaction list ----------
  function automatic bit mtx(input bit wr, input logic [19:0] a, input logic [7:0] wd,
                             input logic [2:0] md, input int gap, output logic [7:0] rd);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = wd; t.mode = md; t.gap = 16'(gap);
    exp_q.push_back(t);
    rd = 8'h00;
    if (!wr && mrd_q.size() > 0) rd = mrd_q.pop_front();
    return (exp_q.size() - 1) == err_at;
  endfunction

  function automatic bit model_fail();
    txn_t t;
    t.wr = 1'b1; t.addr = 20'h102; t.wdata = 8'h00; t.mode = 3'd0; t.gap = 16'd1;
    exp_q.push_back(t);
    return 1'b0;
  endfunction

  // Returns 1 when training is expected to succeed.
  function automatic bit model(input bit two, input logic [2:0] m0);
    logic [7:0] d;
    bit pass;
    exp_q.delete();
    if (mtx(1'b1, 20'h100, 8'h06, m0, 0, d)) return model_fail();
    if (mtx(1'b1, 20'h101, two ? 8'h82 : 8'h81, m0, 1, d)) return model_fail();
    if (mtx(1'b1, 20'h102, 8'h21, 3'd2, 1, d)) return model_fail();
    pass = 1'b0;
    for (int t = 0; t < MAXTRY && !pass; t++) begin
      if (mtx(1'b0, 20'h202, 8'h00, 3'd2, WAITCYC, d)) return model_fail();
      pass = d[0] && (!two || d[4]);
    end
    if (!pass) return model_fail();
    if (mtx(1'b1, 20'h102, 8'h22, 3'd3, 1, d)) return model_fail();
    pass = 1'b0;
    for (int t = 0; t < MAXTRY && !pass; t++) begin
      if (mtx(1'b0, 20'h202, 8'h00, 3'd3, WAITCYC, d)) return model_fail();
      pass = (d[2:0] == 3'b111) && (!two || d[6:4] == 3'b111);
    end
    if (!pass) return model_fail();
    if (mtx(1'b0, 20'h204, 8'h00, 3'd3, 1, d)) return model_fail();
    if (!d[0]) return model_fail();
    if (mtx(1'b1, 20'h102, 8'h00, 3'd3, 1, d)) return model_fail();
    return 1'b1;
  endfunction

  // ---------------- AUX monitor and responder -------------------------------
  initial begin : aux_side
    bit          prev_req;
    bit          rsp_busy;
    int          wait_n;
    logic        s_wr;
    logic [19:0] s_addr;
    logic [7:0]  s_wdata;
    txn_t        t;
    prev_req = 1'b0; rsp_busy = 1'b0; wait_n = 0;
    s_wr = 1'b0; s_addr = '0; s_wdata = '0;
    forever begin
      @(negedge dpclk);
      if (prev_req && auxack) begin
        last_ref = cyc - 1;
        if (auxreq) proto_err++;
        if (auxwr !== s_wr || auxaddr !== s_addr || auxwdata !== s_wdata) proto_err++;
      end else if (prev_req && auxreq) begin
        if (auxwr !== s_wr || auxaddr !== s_addr || auxwdata !== s_wdata) proto_err++;
      end
      if (auxreq && !prev_req) begin
        s_wr = auxwr; s_addr = auxaddr; s_wdata = auxwdata;
        t.wr = auxwr; t.addr = auxaddr; t.wdata = auxwr ? auxwdata : 8'h00;
        t.mode = phymode; t.gap = 16'(cyc - last_ref - 1);
        got_q.push_back(t);
      end
      prev_req = auxreq;

      auxack = 1'b0;
      auxerr = 1'b0;
      if (auxreq && !rsp_busy) begin
        rsp_busy = 1'b1;
        wait_n = rand_dly ? int'($urandom_range(0, 4)) : 3;
      end
      if (rsp_busy) begin
        if (wait_n == 0) begin
          auxack = 1'b1;
          auxerr = ((got_q.size() - 1) == err_at);
          auxrdata = 8'h00;
          if (!auxwr && rsp_rd_q.size() > 0) auxrdata = rsp_rd_q.pop_front();
          rsp_busy = 1'b0;
        end else begin
          wait_n--;
        end
      end
    end
  end

  // ---------------- one training run against the model --------------------
  task automatic run(input bit two, input int err, input int poke);
    bit exp_done;
    bit finished;
    bit flag_at_end;
    mrd_q    = scen_rd;
    rsp_rd_q = scen_rd;
    err_at   = err;
    got_q.delete();
    proto_err = 0;
    exp_done = model(two, cur_mode);
    @(negedge dpclk);
    start = 1'b1; twolane = two; last_ref = cyc;
    @(negedge dpclk);
    start = 1'b0; twolane = ~two;
    check("start_busy", busy, 1);
    check("start_req", auxreq, 1);
    check("start_flags", {done, fail}, 2'b00);
    finished = 1'b0;
    flag_at_end = 1'b0;
    for (int i = 0; i < 4000 && !finished; i++) begin
      @(negedge dpclk);
      start = 1'b0;
      if (!busy) begin
        finished = 1'b1;
        flag_at_end = done | fail;
      end else if (i == poke) begin
        start = 1'b1;
      end
    end
    check("terminates", finished, 1);
    check("flag_with_busy_fall", flag_at_end, 1);
    @(negedge dpclk);
    check("end_done", done, exp_done);
    check("end_fail", fail, !exp_done);
    check("end_mode", phymode, exp_done ? 3'd1 : 3'd0);
    check("txn_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("txn%0d", k), got_q[k], exp_q[k]);
    check("handshake", proto_err, 0);
    cur_mode = exp_done ? 3'd1 : 3'd0;
  endtask

  initial begin : main
    bit         hit;
    logic [7:0] v;
    int         e, p;
    reset = 1'b1; start = 1'b1; twolane = 1'b1;
    auxack = 1'b0; auxerr = 1'b0; auxrdata = 8'h00;
    repeat (3) @(negedge dpclk);
    check("rst_phymode", phymode, 0);
    check("rst_auxreq", auxreq, 0);
    check("rst_auxwr", auxwr, 0);
    check("rst_auxaddr", auxaddr, 0);
    check("rst_auxwdata", auxwdata, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {done, fail}, 2'b00);
    reset = 1'b0; start = 1'b0;
    repeat (2) @(negedge dpclk);
    check("idle_after_rst", {busy, auxreq}, 2'b00);

    // AUX error on the lane-count write: no training pattern ever appears
    rand_dly = 1'b0;
    scen_rd.delete();
    run(1'b0, 1, -1);

    scen_rd = {8'h01, 8'h07, 8'h01};
    run(1'b0, -1, -1);

    // two-lane CR retry, with a start pulse while busy
    scen_rd = {8'h01, 8'h01, 8'h11, 8'h77, 8'h01};
    run(1'b1, -1, 30);

    // EQ never settles
    scen_rd = {8'h01, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
    run(1'b0, -1, -1);

    // lane alignment lost
    scen_rd = {8'h11, 8'h77, 8'h00};
    run(1'b1, -1, -1);

    // reset while waiting for clock recovery
    got_q.delete(); err_at = -1; rsp_rd_q.delete();
    @(negedge dpclk);
    start = 1'b1; twolane = 1'b1; last_ref = cyc;
    @(negedge dpclk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge dpclk);
      hit = (phymode == 3'd2) && !auxreq;
    end
    check("reached_crwait", hit, 1);
    @(negedge dpclk);
    reset = 1'b1;
    @(negedge dpclk);
    reset = 1'b0;
    check("mid_rst_phymode", phymode, 0);
    check("mid_rst_busy_req", {busy, auxreq}, 2'b00);
    repeat (8) @(negedge dpclk);
    cur_mode = 3'd0;
    scen_rd = {8'h11, 8'h77, 8'h01};
    run(1'b1, -1, -1);

    // randomized runs
    rand_dly = 1'b1;
    for (int s = 0; s < 20; s++) begin
      scen_rd.delete();
      for (int k = 0; k < 16; k++) begin
        v = 8'($urandom);
        if ($urandom_range(0, 2) != 0) v = v | 8'h77;
        scen_rd.push_back(v);
      end
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
      p = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 150)) : -1;
      run(1'($urandom_range(0, 1)), e, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
